// File: rtl/game_over_screen.sv
// game_over_screen: fading full-screen game-over overlay with an "L" glyph and registered RGB888 output.
// Define GAME_OVER_BLINK_EN to make the glyph blink during SHOW; otherwise it is solid FG_COLOR.
module game_over_screen #(
   parameter int          SCREEN_WIDTH  = 1280,
   parameter int          SCREEN_HEIGHT = 720,
   parameter logic [23:0] BG_COLOR      = 24'h800000,
   parameter logic [23:0] FG_COLOR      = 24'hFFFFFF,
   parameter int          FADE_SHIFT    = 5,
   parameter int          BLINK_FRAMES  = 30
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        new_frame_in,
   input  logic        trigger_in,
   input  logic        clear_in,
   output logic [23:0] pixel_out,
   output logic        done_out
);
   localparam int X0 = SCREEN_WIDTH * 40 / 100;
   localparam int X1 = SCREEN_WIDTH * 50 / 100;
   localparam int X2 = SCREEN_WIDTH * 65 / 100;
   localparam int Y0 = SCREEN_HEIGHT * 25 / 100;
   localparam int Y1 = SCREEN_HEIGHT * 60 / 100;
   localparam int Y2 = SCREEN_HEIGHT * 75 / 100;
   localparam logic [FADE_SHIFT:0] FULL = {1'b1, {FADE_SHIFT{1'b0}}};

   if (FADE_SHIFT < 1 || FADE_SHIFT > 7 || BLINK_FRAMES < 1) begin : g_bad_params
      $error("game_over_screen: FADE_SHIFT must be 1..7 and BLINK_FRAMES >= 1");
   end

   typedef enum logic [1:0] {IDLE, FADE, SHOW} state_t;

   state_t              state;
   logic [FADE_SHIFT:0] level;
   logic                visible, glyph;
   logic [23:0]         fade_col, show_col, pix_next;
   int                  x, y;

`ifdef GAME_OVER_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
`endif

   // 8b x (FADE_SHIFT+1)b product, truncated back to 8 bits after the shift
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [FADE_SHIFT:0] l);
      logic [FADE_SHIFT+8:0] p;
      p = {{(FADE_SHIFT + 1){1'b0}}, c} * {8'b0, l};
      return p[FADE_SHIFT +: 8];
   endfunction

   assign x        = int'(hcount_in);
   assign y        = int'(vcount_in);
   assign visible  = x < SCREEN_WIDTH && y < SCREEN_HEIGHT;
   assign glyph    = x > X0 && y < Y2 && ((x < X1 && y > Y0) || (x < X2 && y > Y1));
   assign fade_col = {scale(BG_COLOR[23:16], level), scale(BG_COLOR[15:8], level), scale(BG_COLOR[7:0], level)};
`ifdef GAME_OVER_BLINK_EN
   assign show_col = glyph && !blink_phase ? FG_COLOR : BG_COLOR;
`else
   assign show_col = glyph ? FG_COLOR : BG_COLOR;
`endif
   assign pix_next = !visible ? 24'h0 : state == FADE ? fade_col : state == SHOW ? show_col : 24'h0;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= IDLE;
         level     <= '0;
         pixel_out <= '0;
         done_out  <= 1'b0;
`ifdef GAME_OVER_BLINK_EN
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
`endif
      end else begin
         pixel_out <= pix_next;
         done_out  <= state == SHOW;
         if (clear_in) begin
            state <= IDLE;
            level <= '0;
`ifdef GAME_OVER_BLINK_EN
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: if (trigger_in) begin
                  state <= FADE;
                  level <= '0;
               end
               FADE: if (new_frame_in) begin
                  level <= level + 1'b1;
                  if (level == FULL - 1'b1) begin
                     state <= SHOW;
`ifdef GAME_OVER_BLINK_EN
                     blink_cnt   <= '0;
                     blink_phase <= 1'b0;
`endif
                  end
               end
               SHOW: begin
`ifdef GAME_OVER_BLINK_EN
                  if (new_frame_in) begin
                     blink_cnt <= blink_cnt == BLAST ? '0 : blink_cnt + 1'b1;
                     if (blink_cnt == BLAST) blink_phase <= ~blink_phase;
                  end
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
